// File: rtl/dpram_ctrl_pkg.sv
// Shared types and helpers for the dual-port RAM front-end controller.
package dpram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Address width for a given depth, never narrower than one bit.
    function automatic int calc_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dpram_clr_seq.sv
// Clear sequencer: walks the lower half of the array while the upper half
// is covered by the second port, flags the last step, restarts on request.
module dpram_clr_seq
    import dpram_ctrl_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    output logic [AW-1:0] clr_cnt,
    output logic          clr_last
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH / 2 - 1);

    // Clear counter; wraps to zero after the last step so a later restart
    // from RUN always begins at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (restart) begin
            clr_cnt <= '0;
        end else if (en) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + AW'(1);
        end
    end

    assign clr_last = en & (clr_cnt == LAST);

endmodule

// File: rtl/dpram_ctrl.sv
// Dual-port RAM front end: clears the array after reset or on init_req,
// then arbitrates per-port requests with port A winning address conflicts.
//
// state | meaning
// CLEAR | both ports write INIT_VAL over the array, requests refused
// RUN   | requests accepted, read responses returned one cycle later
module dpram_ctrl
    import dpram_ctrl_pkg::*;
#(
    parameter  int                   DEPTH    = 1024,
    parameter  int                   D_WIDTH  = 8,
    parameter  logic [D_WIDTH-1:0]   INIT_VAL = '0,
    localparam int                   AW       = calc_aw(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_req,
    output logic               init_done,

    input  logic               a_req_valid,
    input  logic               a_req_we,
    input  logic [AW-1:0]      a_req_addr,
    input  logic [D_WIDTH-1:0] a_req_wdata,
    output logic               a_req_ready,
    output logic               a_rsp_valid,
    output logic [D_WIDTH-1:0] a_rsp_data,

    input  logic               b_req_valid,
    input  logic               b_req_we,
    input  logic [AW-1:0]      b_req_addr,
    input  logic [D_WIDTH-1:0] b_req_wdata,
    output logic               b_req_ready,
    output logic               b_rsp_valid,
    output logic [D_WIDTH-1:0] b_rsp_data,

    output logic               ram_we_a,
    output logic [AW-1:0]      ram_addr_a,
    output logic [D_WIDTH-1:0] ram_din_a,
    input  logic [D_WIDTH-1:0] ram_dout_a,

    output logic               ram_we_b,
    output logic [AW-1:0]      ram_addr_b,
    output logic [D_WIDTH-1:0] ram_din_b,
    input  logic [D_WIDTH-1:0] ram_dout_b
);

    localparam logic [AW-1:0] HALF = AW'(DEPTH / 2);

    state_t        state;
    state_t        state_nxt;
    logic          clr_en;
    logic          clr_last;
    logic [AW-1:0] clr_cnt;
    logic          addr_conflict;

    assign clr_en = (state == CLEAR);

    dpram_clr_seq #(
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .en       (clr_en),
        .restart  (init_req),
        .clr_cnt  (clr_cnt),
        .clr_last (clr_last)
    );

    // A write on either side to the same word means B must wait a cycle.
    assign addr_conflict = a_req_valid & b_req_valid &
                           (a_req_addr == b_req_addr) & (a_req_we | b_req_we);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; init_req on the final clear step keeps us clearing.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (!init_req && clr_last) state_nxt = RUN;
            RUN:     if (init_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // Output decode; rst gates the write enables so nothing is written
    // while reset is held.
    always_comb begin
        init_done   = 1'b0;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        ram_we_a    = 1'b0;
        ram_we_b    = 1'b0;
        ram_addr_a  = a_req_addr;
        ram_addr_b  = b_req_addr;
        ram_din_a   = a_req_wdata;
        ram_din_b   = b_req_wdata;
        case (state)
            CLEAR: begin
                ram_we_a   = ~rst;
                ram_we_b   = ~rst;
                ram_addr_a = clr_cnt;
                ram_addr_b = clr_cnt + HALF;
                ram_din_a  = INIT_VAL;
                ram_din_b  = INIT_VAL;
            end
            RUN: begin
                init_done   = 1'b1;
                a_req_ready = 1'b1;
                b_req_ready = ~addr_conflict;
                ram_we_a    = ~rst & a_req_valid & a_req_we;
                ram_we_b    = ~rst & b_req_valid & b_req_we & ~addr_conflict;
            end
            default: ;
        endcase
    end

    // Read response valid, one cycle after an accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
        end else begin
            a_rsp_valid <= a_req_valid & a_req_ready & ~a_req_we;
            b_rsp_valid <= b_req_valid & b_req_ready & ~b_req_we;
        end
    end

    assign a_rsp_data = ram_dout_a;
    assign b_rsp_data = ram_dout_b;

endmodule
